// File: rtl/amo_shift_resp_pkg.sv
// Shared definitions for the AMO shift read-modify-write engine:
// function codes, FSM states, shift-op encoding and Wishbone constants.
package amo_shift_resp_pkg;

  // AMO function codes, register-amount variants
  localparam logic [5:0] FUNC_SHL  = 6'h0C;
  localparam logic [5:0] FUNC_SHR  = 6'h0D;
  localparam logic [5:0] FUNC_ASR  = 6'h0E;
  localparam logic [5:0] FUNC_ROL  = 6'h0F;

  // AMO function codes, immediate-amount variants
  localparam logic [5:0] FUNC_SHLI = 6'h2C;
  localparam logic [5:0] FUNC_SHRI = 6'h2D;
  localparam logic [5:0] FUNC_ASRI = 6'h2E;
  localparam logic [5:0] FUNC_ROLI = 6'h2F;

  // Wishbone byte-select width; every access is a full word
  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] SEL_ALL = '1;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RSP  = 2'd3
  } amo_state_e;

  // Shift operation; matches the low two bits of every supported func
  typedef enum logic [1:0] {
    OP_SHL = 2'd0,
    OP_SHR = 2'd1,
    OP_ASR = 2'd2,
    OP_ROL = 2'd3
  } shift_op_e;

  // True for the eight supported function codes
  function automatic logic func_is_valid(input logic [5:0] func);
    logic ok;
    ok = 1'b0;
    case (func)
      FUNC_SHL, FUNC_SHR, FUNC_ASR, FUNC_ROL,
      FUNC_SHLI, FUNC_SHRI, FUNC_ASRI, FUNC_ROLI: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Immediate-amount variants live in the 0x2C-0x2F group
  function automatic logic func_uses_imm(input logic [5:0] func);
    return func[5];
  endfunction

  // Shift operation selected by a function code
  function automatic shift_op_e func_to_op(input logic [5:0] func);
    return shift_op_e'(func[1:0]);
  endfunction

endpackage

// File: rtl/amo_shift32.sv
// Combinational 32-bit shifter: logical left/right, arithmetic right, rotate left.
module amo_shift32
  import amo_shift_resp_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [4:0]  amt,
  input  logic [31:0] a,
  output logic [31:0] res
);

  logic [63:0] rot;

  // Select the shift result; rotate takes the upper half of a doubled word
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    rot = {a, a} << amt;
    res = a;
    case (shift_op_e'(op))
      OP_SHL:  res = a << amt;
      OP_SHR:  res = a >> amt;
      OP_ASR:  res = $unsigned($signed(a) >>> amt);
      OP_ROL:  res = rot[63:32];
      default: res = a;
    endcase
  end

endmodule

// File: rtl/amo_shift_resp.sv
// AMO shift engine: accepts a shift request, performs a locked Wishbone
// read-modify-write of one word and returns the old word as a response.
module amo_shift_resp
  import amo_shift_resp_pkg::*;
#(
  parameter int AW          = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // request
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [5:0]       req_func_i,
  input  logic [AW-1:0]    req_adr_i,
  input  logic [31:0]      req_b_i,
  input  logic [4:0]       req_imm_i,
  input  logic [3:0]       req_tag_i,
  // response
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [31:0]      resp_dat_o,
  output logic [3:0]       resp_tag_o,
  output logic             resp_err_o,
  // Wishbone classic master
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [SEL_W-1:0] sel_o,
  output logic [AW-1:0]    adr_o,
  output logic [31:0]      dat_o,
  input  logic [31:0]      dat_i,
  input  logic             ack_i,
  input  logic             err_i
);

  // Phase counter must hold 0 .. ACK_TIMEOUT-1
  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  amo_state_e  state_q, state_d;
  shift_op_e   op_q;
  logic [4:0]  amt_q;
  logic [AW-1:0] adr_q;
  logic [3:0]  tag_q;
  logic [31:0] old_q;
  logic [31:0] new_q;
  logic [31:0] shift_res;
  logic        err_q;
  logic [CW-1:0] cnt_q;

  logic accept;
  logic timeout;
  logic bus_fail;
  logic unused_b;

  // Only the low five bits of the register amount are meaningful
  assign unused_b = ^req_b_i[31:5];

  assign accept   = (state_q == ST_IDLE) && req_valid_i;
  assign timeout  = (cnt_q == CNT_LAST);
  // err_i wins over a simultaneous ack_i; a timed-out phase behaves as err_i
  assign bus_fail = err_i || timeout;

  // Shift the word as it arrives so the new value is ready when the read acks
  amo_shift32 u_shift (
    .op  (op_q),
    .amt (amt_q),
    .a   (dat_i),
    .res (shift_res)
  );

  // State register; reset abandons any operation in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignment so all registers see pre-edge values.
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_dat_o   = '0;
    resp_tag_o   = '0;
    resp_err_o   = 1'b0;
    cyc_o        = 1'b0;
    stb_o        = 1'b0;
    we_o         = 1'b0;
    sel_o        = '0;
    adr_o        = '0;
    dat_o        = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_d = func_is_valid(req_func_i) ? ST_RD : ST_RSP;
        end
      end

      ST_RD: begin
        cyc_o = 1'b1;
        stb_o = 1'b1;
        sel_o = SEL_ALL;
        adr_o = adr_q;
        if (bus_fail) begin
          state_d = ST_RSP;
        end else if (ack_i) begin
          state_d = ST_WR;
        end
      end

      ST_WR: begin
        cyc_o = 1'b1;
        stb_o = 1'b1;
        we_o  = 1'b1;
        sel_o = SEL_ALL;
        adr_o = adr_q;
        dat_o = new_q;
        if (bus_fail || ack_i) begin
          state_d = ST_RSP;
        end
      end

      ST_RSP: begin
        resp_valid_o = 1'b1;
        resp_dat_o   = old_q;
        resp_tag_o   = tag_q;
        resp_err_o   = err_q;
        if (resp_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture, read data capture, error flag and per-phase timeout counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q  <= OP_SHL;
      amt_q <= '0;
      adr_q <= '0;
      tag_q <= '0;
      old_q <= '0;
      new_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= func_to_op(req_func_i);
            amt_q <= func_uses_imm(req_func_i) ? req_imm_i : req_b_i[4:0];
            adr_q <= req_adr_i;
            tag_q <= req_tag_i;
            // Old word stays zero unless the read phase completes
            old_q <= '0;
            new_q <= '0;
            err_q <= !func_is_valid(req_func_i);
            cnt_q <= '0;
          end
        end

        ST_RD: begin
          if (bus_fail) begin
            err_q <= 1'b1;
          end else if (ack_i) begin
            old_q <= dat_i;
            new_q <= shift_res;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_WR: begin
          if (bus_fail) begin
            err_q <= 1'b1;
          end else if (!ack_i) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_amo_shift_resp.sv
// Self-checking bench for amo_shift_resp: directed cases plus randomized
// operations against a word-level reference model and a Wishbone slave model.
module tb_amo_shift_resp;
  import amo_shift_resp_pkg::*;

  localparam int AW = 32;
  localparam int T  = 16;   // ACK_TIMEOUT used for this bench
  localparam int HANG = 1000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [5:0]  req_func_i = '0;
  logic [AW-1:0] req_adr_i = '0;
  logic [31:0] req_b_i = '0;
  logic [4:0]  req_imm_i = '0;
  logic [3:0]  req_tag_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_dat_o;
  logic [3:0]  resp_tag_o;
  logic        resp_err_o;
  logic        cyc_o, stb_o, we_o;
  logic [3:0]  sel_o;
  logic [AW-1:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i, err_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  amo_shift_resp #(.AW(AW), .ACK_TIMEOUT(T)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_func_i   (req_func_i),
    .req_adr_i    (req_adr_i),
    .req_b_i      (req_b_i),
    .req_imm_i    (req_imm_i),
    .req_tag_i    (req_tag_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_dat_o   (resp_dat_o),
    .resp_tag_o   (resp_tag_o),
    .resp_err_o   (resp_err_o),
    .cyc_o        (cyc_o),
    .stb_o        (stb_o),
    .we_o         (we_o),
    .sel_o        (sel_o),
    .adr_o        (adr_o),
    .dat_o        (dat_o),
    .dat_i        (dat_i),
    .ack_i        (ack_i),
    .err_i        (err_i)
  );

  // ---------------- Wishbone slave model ----------------
  bit [31:0] mem [16];
  int  rd_wait = 0, wr_wait = 0;
  bit  rd_err = 1'b0, wr_err = 1'b0;
  int  wcnt = 0;
  int  wr_count = 0;
  int  cyc_count = 0;
  bit  preload_go = 1'b0;
  logic [3:0]  preload_adr = '0;
  logic [31:0] preload_dat = '0;

  logic phase_err;
  logic phase_done;
  assign phase_err  = we_o ? wr_err : rd_err;
  assign phase_done = wcnt >= (we_o ? wr_wait : rd_wait);
  assign ack_i = stb_o && phase_done && !phase_err;
  assign err_i = stb_o && phase_done && phase_err;
  assign dat_i = mem[adr_o[3:0]];

  always @(posedge clk_i) begin
    if (preload_go) mem[preload_adr] <= preload_dat;
    if (stb_o && we_o && ack_i) begin
      mem[adr_o[3:0]] <= dat_o;
      wr_count <= wr_count + 1;
    end
    if (cyc_o) cyc_count <= cyc_count + 1;
    if (!stb_o || ack_i || err_i) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // ---------------- reference model ----------------
  bit [31:0] model_mem [16];

  function automatic bit ref_valid(input logic [5:0] f);
    return f inside {[6'h0C:6'h0F], [6'h2C:6'h2F]};
  endfunction

  // Shift one bit position at a time, straight from the operation definitions
  function automatic logic [31:0] ref_shift(input logic [5:0] f, input logic [31:0] x, input int n);
    logic [31:0] v;
    v = x;
    for (int i = 0; i < n; i++) begin
      case (f[1:0])
        2'd0: v = v * 2;
        2'd1: v = v / 2;
        2'd2: v = (v / 2) | (v & 32'h8000_0000);
        default: v = (v * 2) | (v / 32'h8000_0000);
      endcase
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk_i);
    preload_adr = a;
    preload_dat = v;
    preload_go  = 1'b1;
    @(posedge clk_i);
    #1;
    preload_go  = 1'b0;
    model_mem[a] = v;
  endtask

  // One full request/response transaction with slave behaviour per phase
  task automatic run_op(input string name, input logic [5:0] f, input logic [3:0] a,
                        input logic [31:0] b, input logic [4:0] imm, input logic [3:0] tag,
                        input int rw, input int ww, input bit re, input bit we, input int hold);
    int amount, rd_len, wr_len, exp_lat, exp_cyc, exp_wr, n, c0, w0;
    bit rd_fail, wr_fail, exp_err, stable;
    logic [31:0] old_w, exp_dat;

    amount  = f[5] ? int'(imm) : int'(b[4:0]);
    old_w   = model_mem[a];
    rd_fail = re || (rw + 1 >= T);
    wr_fail = we || (ww + 1 >= T);
    rd_len  = (rw + 1 < T) ? rw + 1 : T;
    wr_len  = (ww + 1 < T) ? ww + 1 : T;

    if (!ref_valid(f)) begin
      exp_lat = 1; exp_err = 1'b1; exp_dat = '0; exp_cyc = 0; exp_wr = 0;
    end else if (rd_fail) begin
      exp_lat = rd_len + 1; exp_err = 1'b1; exp_dat = '0; exp_cyc = rd_len; exp_wr = 0;
    end else begin
      exp_lat = rd_len + wr_len + 1; exp_err = wr_fail; exp_dat = old_w;
      exp_cyc = rd_len + wr_len; exp_wr = wr_fail ? 0 : 1;
      if (!wr_fail) model_mem[a] = ref_shift(f, old_w, amount);
    end

    @(negedge clk_i);
    rd_wait = rw; wr_wait = ww; rd_err = re; wr_err = we;
    c0 = cyc_count; w0 = wr_count;
    req_valid_i = 1'b1;
    req_func_i  = f;
    req_adr_i   = AW'(a);
    req_b_i     = b;
    req_imm_i   = imm;
    req_tag_i   = tag;
    check({name, ".req_ready"}, 32'(req_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    n = 1;
    while (resp_valid_o !== 1'b1 && n < 4 * T + 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check({name, ".resp_valid"}, 32'(resp_valid_o), 32'd1);
    check({name, ".latency"}, 32'(n), 32'(exp_lat));
    check({name, ".resp_dat"}, resp_dat_o, exp_dat);
    check({name, ".resp_tag"}, 32'(resp_tag_o), 32'(tag));
    check({name, ".resp_err"}, 32'(resp_err_o), 32'(exp_err));

    // Response must hold while the consumer stalls
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      if (resp_valid_o !== 1'b1 || resp_dat_o !== exp_dat || resp_tag_o !== tag ||
          resp_err_o !== exp_err || req_ready_o !== 1'b0 || cyc_o !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) check({name, ".hold_stable"}, 32'(stable), 32'd1);

    @(negedge clk_i);
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    resp_ready_i = 1'b0;
    check({name, ".idle_after"}, 32'(req_ready_o), 32'd1);
    check({name, ".cyc_cycles"}, 32'(cyc_count - c0), 32'(exp_cyc));
    check({name, ".writes"}, 32'(wr_count - w0), 32'(exp_wr));
    check({name, ".mem"}, mem[a], model_mem[a]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    logic [5:0] f;
    logic [3:0] a;

    // ---- reset state ----
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst.cyc", 32'(cyc_o), 0);
    check("rst.stb", 32'(stb_o), 0);
    check("rst.we", 32'(we_o), 0);
    check("rst.sel", 32'(sel_o), 0);
    check("rst.adr", adr_o, 0);
    check("rst.dat", dat_o, 0);
    check("rst.resp_valid", 32'(resp_valid_o), 0);
    check("rst.resp_dat", resp_dat_o, 0);
    check("rst.resp_tag", 32'(resp_tag_o), 0);
    check("rst.resp_err", 32'(resp_err_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("rst.req_ready", 32'(req_ready_o), 1);

    // ---- directed examples ----
    preload(4'd1, 32'h0000_0001);
    run_op("shl_b4", 6'h0C, 4'd1, 32'd4, 5'd0, 4'h3, 0, 0, 0, 0, 0);
    check("shl_b4.value", mem[1], 32'h0000_0010);

    preload(4'd2, 32'h8000_0000);
    run_op("asri_4", 6'h2E, 4'd2, 32'hFFFF_FFE0, 5'd4, 4'h5, 0, 0, 0, 0, 0);
    check("asri_4.value", mem[2], 32'hF800_0000);

    preload(4'd3, 32'h8000_0000);
    run_op("shr_b24", 6'h0D, 4'd3, 32'h0000_0024, 5'd9, 4'h6, 0, 0, 0, 0, 0);
    check("shr_b24.value", mem[3], 32'h0800_0000);

    preload(4'd4, 32'h8000_0001);
    run_op("roli_1", 6'h2F, 4'd4, 32'd0, 5'd1, 4'h7, 0, 0, 0, 0, 0);
    check("roli_1.value", mem[4], 32'h0000_0003);

    preload(4'd5, 32'hA5A5_1234);
    run_op("amt0", 6'h0C, 4'd5, 32'hFFFF_FFE0, 5'd7, 4'h8, 0, 0, 0, 0, 0);

    run_op("bad_func", 6'h10, 4'd6, 32'd3, 5'd3, 4'h9, 0, 0, 0, 0, 0);

    preload(4'd7, 32'h1234_5678);
    run_op("rd_err", 6'h0C, 4'd7, 32'd1, 5'd0, 4'hA, 1, 0, 1, 0, 0);
    run_op("rd_timeout", 6'h0D, 4'd7, 32'd1, 5'd0, 4'hB, HANG, 0, 0, 0, 0);
    run_op("wr_err", 6'h0E, 4'd7, 32'd1, 5'd0, 4'hC, 0, 2, 0, 1, 0);
    run_op("wr_timeout", 6'h2F, 4'd7, 32'd0, 5'd8, 4'hD, 0, HANG, 0, 0, 0);
    run_op("hold5", 6'h0F, 4'd7, 32'd12, 5'd0, 4'hE, 2, 1, 0, 0, 5);

    // ---- reset during the write phase ----
    preload(4'd8, 32'h0F0F_0F0F);
    @(negedge clk_i);
    rd_wait = 0; wr_wait = 8; rd_err = 1'b0; wr_err = 1'b0;
    n = wr_count;
    req_valid_i = 1'b1;
    req_func_i  = 6'h0C;
    req_adr_i   = AW'(8);
    req_b_i     = 32'd4;
    req_tag_i   = 4'h2;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    for (int i = 0; i < 10 && we_o !== 1'b1; i++) begin
      @(posedge clk_i);
      #1;
    end
    check("rst_wr.in_write", 32'(we_o), 1);
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_wr.cyc", 32'(cyc_o), 0);
    check("rst_wr.stb", 32'(stb_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (resp_valid_o !== 1'b0 || cyc_o !== 1'b0) seen = 1'b1;
    end
    check("rst_wr.no_activity", 32'(seen), 0);
    check("rst_wr.no_write", 32'(wr_count - n), 0);
    check("rst_wr.mem", mem[8], model_mem[8]);
    check("rst_wr.req_ready", 32'(req_ready_o), 1);

    // ---- randomized operations ----
    for (int k = 0; k < 40; k++) begin
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) preload(a, $urandom);
      if ($urandom_range(0, 7) == 0) f = 6'($urandom);
      else f = {1'($urandom_range(0, 1)), 3'b011, 2'($urandom_range(0, 3))};
      run_op("rand", f, a, $urandom, 5'($urandom), 4'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
             int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
